// File: rtl/c_tile_reader.sv
// Streams one M x N tile out of the C SRAM in row-major order through a small
// occupancy-limited buffer, tagging every element with its row/column.
module c_tile_reader #(
  parameter int M          = 8,
  parameter int N          = 8,
  parameter int DATA_W     = 32,
  parameter int ROW_W      = (M <= 1) ? 1 : $clog2(M),
  parameter int COL_W      = (N <= 1) ? 1 : $clog2(N),
  parameter int RD_LAT     = 1,
  parameter int FIFO_DEPTH = RD_LAT + 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              flush,
  output logic              c_re,
  output logic [ROW_W-1:0]  c_rrow,
  output logic [COL_W-1:0]  c_rcol,
  input  logic [DATA_W-1:0] c_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ROW_W-1:0]  out_row,
  output logic [COL_W-1:0]  out_col,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  localparam int TOTAL = M * N;
  localparam int ISS_W = $clog2(TOTAL + 1);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W = (FIFO_DEPTH <= 1) ? 1 : $clog2(FIFO_DEPTH);

  localparam logic [ISS_W-1:0] TOTAL_C    = ISS_W'(TOTAL);
  localparam logic [ISS_W-1:0] LAST_IDX_C = ISS_W'(TOTAL - 1);
  localparam logic [CNT_W:0]   DEPTH_C    = (CNT_W + 1)'(FIFO_DEPTH);
  localparam logic [PTR_W-1:0] PTR_MAX_C  = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [ROW_W-1:0] ROW_MAX_C  = ROW_W'(M - 1);
  localparam logic [COL_W-1:0] COL_MAX_C  = COL_W'(N - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t state, state_nxt;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_MAX_C) ? '0 : p + PTR_W'(1);
  endfunction

  logic [ISS_W-1:0] issued;
  logic [ROW_W-1:0] row_q;
  logic [COL_W-1:0] col_q;
  logic [CNT_W-1:0] inflight;
  logic [CNT_W-1:0] fifo_cnt;
  logic [CNT_W:0]   occupancy;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             issue;
  logic             last_issue;
  logic             ret_vld;
  logic             pop;
  logic             last_hs;
  logic             row_end;
  logic             col_end;

  // Read-tag delay line: stage i carries the tag of a read issued i+1 cycles ago
  logic [RD_LAT-1:0] vld_p;
  logic [ROW_W-1:0]  row_p  [RD_LAT];
  logic [COL_W-1:0]  col_p  [RD_LAT];
  logic              last_p [RD_LAT];

  logic [DATA_W-1:0] fifo_data [FIFO_DEPTH];
  logic [ROW_W-1:0]  fifo_row  [FIFO_DEPTH];
  logic [COL_W-1:0]  fifo_col  [FIFO_DEPTH];
  logic              fifo_last [FIFO_DEPTH];

  // Reads in flight already own a buffer slot, so the FIFO cannot overflow
  assign occupancy  = {1'b0, inflight} + {1'b0, fifo_cnt};
  assign row_end    = (row_q == ROW_MAX_C);
  assign col_end    = (col_q == COL_MAX_C);
  assign issue      = (state == RUN) && !flush && (issued < TOTAL_C) && (occupancy < DEPTH_C);
  assign last_issue = issue && (issued == LAST_IDX_C);
  assign ret_vld    = vld_p[RD_LAT-1];
  assign pop        = out_valid && out_ready;
  assign last_hs    = pop && out_last;

  assign c_re   = issue;
  assign c_rrow = row_q;
  assign c_rcol = col_q;
  assign busy   = (state != IDLE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last_issue) state_nxt = DRAIN;
      DRAIN:   if (last_hs) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) done <= 1'b0;
    else     done <= (state == DRAIN) && last_hs && !flush;
  end

  always_ff @(posedge clk) begin
    if (rst || flush || (state == IDLE)) begin
      issued <= '0;
      row_q  <= '0;
      col_q  <= '0;
    end else if (issue) begin
      issued <= issued + ISS_W'(1);
      if (col_end) begin
        col_q <= '0;
        row_q <= row_end ? '0 : row_q + ROW_W'(1);
      end else begin
        col_q <= col_q + COL_W'(1);
      end
    end
  end

  // Read issue -> data return (RD_LAT stages)
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      vld_p <= '0;
    end else begin
      vld_p[0] <= issue;
      for (int i = 1; i < RD_LAT; i++) vld_p[i] <= vld_p[i-1];
    end
  end

  always_ff @(posedge clk) begin
    row_p[0]  <= row_q;
    col_p[0]  <= col_q;
    last_p[0] <= row_end && col_end;
    for (int i = 1; i < RD_LAT; i++) begin
      row_p[i]  <= row_p[i-1];
      col_p[i]  <= col_p[i-1];
      last_p[i] <= last_p[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) inflight <= '0;
    else              inflight <= inflight + CNT_W'(issue) - CNT_W'(ret_vld);
  end

  // Returned data -> output buffer
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (ret_vld) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)     rd_ptr <= ptr_inc(rd_ptr);
      fifo_cnt <= fifo_cnt + CNT_W'(ret_vld) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (ret_vld) begin
      fifo_data[wr_ptr] <= c_rdata;
      fifo_row[wr_ptr]  <= row_p[RD_LAT-1];
      fifo_col[wr_ptr]  <= col_p[RD_LAT-1];
      fifo_last[wr_ptr] <= last_p[RD_LAT-1];
    end
  end

  // Head entry is held in flops until popped; outputs read as zero while empty
  assign out_valid = (fifo_cnt != '0);
  assign out_data  = out_valid ? fifo_data[rd_ptr] : '0;
  assign out_row   = out_valid ? fifo_row[rd_ptr]  : '0;
  assign out_col   = out_valid ? fifo_col[rd_ptr]  : '0;
  assign out_last  = out_valid && fifo_last[rd_ptr];

endmodule

// File: tb/tb_c_tile_reader.sv
// Directed bench for c_tile_reader: a 2x2/RD_LAT=1, an 8x8/RD_LAT=3 and a
// 1x1/RD_LAT=2 instance, each fed by its own C SRAM model.
module tb_c_tile_reader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic logic [31:0] mval(input int r, input int c);
    return 32'(r * 16 + c);
  endfunction

  // 2x2, RD_LAT=1
  logic        a_start, a_flush, a_re, a_valid, a_rdy, a_last, a_busy, a_done;
  logic [0:0]  a_rrow, a_rcol, a_row, a_col;
  logic [31:0] a_rdata, a_data;

  c_tile_reader #(.M(2), .N(2), .DATA_W(32), .RD_LAT(1)) u_a (
    .clk(clk), .rst(rst), .start(a_start), .flush(a_flush),
    .c_re(a_re), .c_rrow(a_rrow), .c_rcol(a_rcol), .c_rdata(a_rdata),
    .out_valid(a_valid), .out_ready(a_rdy), .out_data(a_data),
    .out_row(a_row), .out_col(a_col), .out_last(a_last),
    .busy(a_busy), .done(a_done));

  always @(posedge clk)
    a_rdata <= a_re ? mval(int'(a_rrow), int'(a_rcol)) : 32'hBAD0_BAD0;

  // 8x8, RD_LAT=3, FIFO_DEPTH defaults to 5
  logic        b_start, b_flush, b_re, b_valid, b_rdy, b_last, b_busy, b_done;
  logic [2:0]  b_rrow, b_rcol, b_row, b_col;
  logic [31:0] b_rdata, b_data;
  logic [31:0] b_pipe [3];

  c_tile_reader #(.M(8), .N(8), .DATA_W(32), .RD_LAT(3)) u_b (
    .clk(clk), .rst(rst), .start(b_start), .flush(b_flush),
    .c_re(b_re), .c_rrow(b_rrow), .c_rcol(b_rcol), .c_rdata(b_rdata),
    .out_valid(b_valid), .out_ready(b_rdy), .out_data(b_data),
    .out_row(b_row), .out_col(b_col), .out_last(b_last),
    .busy(b_busy), .done(b_done));

  always @(posedge clk) begin
    b_pipe[0] <= b_re ? mval(int'(b_rrow), int'(b_rcol)) : 32'hBAD0_BAD0;
    b_pipe[1] <= b_pipe[0];
    b_pipe[2] <= b_pipe[1];
  end
  assign b_rdata = b_pipe[2];

  // 1x1, RD_LAT=2
  logic        d_start, d_flush, d_re, d_valid, d_rdy, d_last, d_busy, d_done;
  logic [0:0]  d_rrow, d_rcol, d_row, d_col;
  logic [31:0] d_rdata, d_data;
  logic [31:0] d_pipe [2];

  c_tile_reader #(.M(1), .N(1), .DATA_W(32), .RD_LAT(2)) u_d (
    .clk(clk), .rst(rst), .start(d_start), .flush(d_flush),
    .c_re(d_re), .c_rrow(d_rrow), .c_rcol(d_rcol), .c_rdata(d_rdata),
    .out_valid(d_valid), .out_ready(d_rdy), .out_data(d_data),
    .out_row(d_row), .out_col(d_col), .out_last(d_last),
    .busy(d_busy), .done(d_done));

  always @(posedge clk) begin
    d_pipe[0] <= d_re ? (32'h00C0_FF00 | {30'd0, d_rrow, d_rcol}) : 32'hBAD0_BAD0;
    d_pipe[1] <= d_pipe[0];
  end
  assign d_rdata = d_pipe[1];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; a_start = 1'b1; b_start = 1'b1; d_flush = 1'b1;
    tick(); tick();
    n_tests++;
    if ({a_re, a_valid, a_last, a_busy, a_done, a_rrow, a_rcol, a_row, a_col, a_data} !== '0)
      begin n_fail++; $display("FAIL reset_a: got valid=%b busy=%b re=%b data=%h, required all zero", a_valid, a_busy, a_re, a_data); end
    n_tests++;
    if ({b_re, b_valid, b_last, b_busy, b_done, b_rrow, b_rcol, b_row, b_col, b_data} !== '0)
      begin n_fail++; $display("FAIL reset_b: got valid=%b busy=%b re=%b data=%h, required all zero", b_valid, b_busy, b_re, b_data); end
    n_tests++;
    if ({d_re, d_valid, d_last, d_busy, d_done, d_rrow, d_rcol, d_row, d_col, d_data} !== '0)
      begin n_fail++; $display("FAIL reset_d: got valid=%b busy=%b re=%b data=%h, required all zero", d_valid, d_busy, d_re, d_data); end
    a_start = 1'b0; b_start = 1'b0; d_flush = 1'b0;
    rst = 1'b0;
    tick();
    n_tests++;
    if ({a_busy, b_busy} !== 2'b00)
      begin n_fail++; $display("FAIL reset_start_override: got busy a=%b b=%b, required 0 0", a_busy, b_busy); end
  endtask

  // Cycle-exact 2x2 stream; table rows are cycles 1..8 after start,
  // ctl = {out_valid, out_last, done, busy, c_re}
  task automatic test_basic_2x2();
    logic [4:0]  exp_ctl [8] = '{5'b00011, 5'b00011, 5'b10011, 5'b10011,
                                 5'b10010, 5'b11010, 5'b00100, 5'b00000};
    logic [31:0] exp_dat [8] = '{32'h0, 32'h0, 32'h00, 32'h01, 32'h10, 32'h11, 32'h0, 32'h0};
    a_rdy = 1'b1;
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    for (int c = 0; c < 8; c++) begin
      n_tests++;
      if ({a_valid, a_last, a_done, a_busy, a_re} !== exp_ctl[c])
        begin n_fail++; $display("FAIL basic_ctl cycle %0d: got %b, required %b", c + 1, {a_valid, a_last, a_done, a_busy, a_re}, exp_ctl[c]); end
      if (exp_ctl[c][4]) begin
        n_tests++;
        if ({a_data, a_row, a_col} !== {exp_dat[c], exp_dat[c][4], exp_dat[c][0]})
          begin n_fail++; $display("FAIL basic_data cycle %0d: got %h (%0d,%0d), required %h", c + 1, a_data, a_row, a_col, exp_dat[c]); end
      end
      if (exp_ctl[c][0]) begin
        n_tests++;
        if ({a_rrow, a_rcol} !== 2'(c))
          begin n_fail++; $display("FAIL basic_addr cycle %0d: got (%0d,%0d), required index %0d", c + 1, a_rrow, a_rcol, c); end
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    test_basic_2x2();
  endtask

  task automatic test_start_while_busy();
    int n_acc = 0;
    int n_done = 0;
    a_rdy = 1'b1;
    a_start = 1'b1;
    tick();
    for (int c = 1; c <= 20; c++) begin
      a_start = (c == 2) || (c == 5);
      if (a_valid && a_rdy) begin
        n_tests++;
        if ({a_data, a_row, a_col} !== {mval(n_acc / 2, n_acc % 2), 1'(n_acc / 2), 1'(n_acc % 2)})
          begin n_fail++; $display("FAIL busy_start_elem %0d: got %h, required %h", n_acc, a_data, mval(n_acc / 2, n_acc % 2)); end
        n_acc++;
      end
      if (a_done) n_done++;
      tick();
    end
    a_start = 1'b0;
    n_tests++;
    if (n_acc !== 4 || n_done !== 1 || a_busy !== 1'b0)
      begin n_fail++; $display("FAIL busy_start_count: got elems=%0d dones=%0d busy=%b, required 4 1 0", n_acc, n_done, a_busy); end
  endtask

  task automatic test_start_flush_same();
    int bad = 0;
    a_start = 1'b1; a_flush = 1'b1;
    tick();
    a_start = 1'b0; a_flush = 1'b0;
    for (int c = 0; c < 4; c++) begin
      if (a_busy || a_re || a_valid) bad++;
      tick();
    end
    n_tests++;
    if (bad !== 0)
      begin n_fail++; $display("FAIL start_flush_same: got %0d active cycles, required 0", bad); end
  endtask

  // 1x1 tile; ctl = {out_valid, out_last, done, busy, c_re} for cycles 1..6
  task automatic test_single();
    logic [4:0] exp_ctl [6] = '{5'b00011, 5'b00010, 5'b00010, 5'b11010, 5'b00100, 5'b00000};
    d_rdy = 1'b1;
    d_start = 1'b1;
    tick();
    d_start = 1'b0;
    for (int c = 0; c < 6; c++) begin
      n_tests++;
      if ({d_valid, d_last, d_done, d_busy, d_re} !== exp_ctl[c])
        begin n_fail++; $display("FAIL single_ctl cycle %0d: got %b, required %b", c + 1, {d_valid, d_last, d_done, d_busy, d_re}, exp_ctl[c]); end
      if (c == 3) begin
        n_tests++;
        if ({d_data, d_row, d_col} !== {32'h00C0_FF00, 1'b0, 1'b0})
          begin n_fail++; $display("FAIL single_data: got %h (%0d,%0d), required 00c0ff00 (0,0)", d_data, d_row, d_col); end
      end
      tick();
    end
  endtask

  // Full 8x8 tile on u_b. pattern 0: ready high, 1: ready toggles 1,0.
  // hold > 0 keeps ready low for the first hold cycles.
  task automatic test_full_tile_b(input int pattern, input int hold);
    int          idx = 0;
    int          nre = 0;
    int          max_out = 0;
    int          last_acc = -10;
    bit          prev_stall = 1'b0;
    bit          finished = 1'b0;
    logic [37:0] prev_out = '0;
    b_rdy = 1'b0;
    b_start = 1'b1;
    tick();
    b_start = 1'b0;
    for (int c = 1; c <= 2000; c++) begin
      if (c <= hold)         b_rdy = 1'b0;
      else if (pattern == 1) b_rdy = (c % 2 == 1);
      else                   b_rdy = 1'b1;
      if (b_re) nre++;
      if (prev_stall) begin
        n_tests++;
        if (!b_valid || {b_data, b_row, b_col} !== prev_out)
          begin n_fail++; $display("FAIL stall_stable cycle %0d: got v=%b %h, required v=1 %h", c, b_valid, {b_data, b_row, b_col}, prev_out); end
      end
      prev_stall = b_valid && !b_rdy;
      prev_out   = {b_data, b_row, b_col};
      if (b_valid && b_rdy) begin
        n_tests++;
        if ({b_data, b_row, b_col, b_last} !== {mval(idx / 8, idx % 8), 3'(idx / 8), 3'(idx % 8), idx == 63})
          begin n_fail++; $display("FAIL tile_elem %0d: got %h (%0d,%0d) last=%b, required %h", idx, b_data, b_row, b_col, b_last, mval(idx / 8, idx % 8)); end
        idx++;
        last_acc = c;
      end
      if (nre - idx > max_out) max_out = nre - idx;
      if (hold > 0 && c == hold) begin
        n_tests++;
        if (nre !== 5 || b_re !== 1'b0)
          begin n_fail++; $display("FAIL backpressure_reads: got %0d reads re=%b, required 5 re=0", nre, b_re); end
      end
      if (b_done) begin
        n_tests++;
        if (idx !== 64 || last_acc !== c - 1)
          begin n_fail++; $display("FAIL tile_done: got elems=%0d at cycle %0d last_acc=%0d, required 64 one cycle after", idx, c, last_acc); end
        finished = 1'b1;
        break;
      end
      tick();
    end
    n_tests++;
    if (!finished)
      begin n_fail++; $display("FAIL tile_timeout: got %0d elems and no done, required done", idx); end
    n_tests++;
    if (max_out > 5)
      begin n_fail++; $display("FAIL tile_occupancy: got %0d outstanding, required <= 5", max_out); end
    b_rdy = 1'b0;
    tick();
  endtask

  task automatic test_flush_mid_tile();
    int idx = 0;
    int bad = 0;
    bit flushed = 1'b0;
    b_rdy = 1'b1;
    b_start = 1'b1;
    tick();
    b_start = 1'b0;
    for (int c = 1; c <= 300; c++) begin
      if (b_valid && idx == 10) begin
        b_flush = 1'b1;
        flushed = 1'b1;
        tick();
        b_flush = 1'b0;
        break;
      end
      if (b_valid && b_rdy) begin
        n_tests++;
        if (b_data !== mval(idx / 8, idx % 8))
          begin n_fail++; $display("FAIL flush_pre_elem %0d: got %h, required %h", idx, b_data, mval(idx / 8, idx % 8)); end
        idx++;
      end
      tick();
    end
    n_tests++;
    if (!flushed)
      begin n_fail++; $display("FAIL flush_reach: got %0d elems, required element 10 at head", idx); end
    n_tests++;
    if ({b_valid, b_busy, b_done, b_re} !== 4'b0000)
      begin n_fail++; $display("FAIL flush_next: got valid=%b busy=%b done=%b re=%b, required 0", b_valid, b_busy, b_done, b_re); end
    for (int c = 0; c < 12; c++) begin
      tick();
      if (b_valid || b_done || b_busy) bad++;
    end
    n_tests++;
    if (bad !== 0)
      begin n_fail++; $display("FAIL flush_quiet: got %0d active cycles, required 0", bad); end
    test_full_tile_b(0, 0);
  endtask

  task automatic test_rst_mid_tile();
    int bad = 0;
    b_rdy = 1'b1;
    b_start = 1'b1;
    tick();
    for (int c = 1; c <= 4; c++) begin
      b_start = (c == 3);
      tick();
    end
    b_start = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_tests++;
    if ({b_re, b_valid, b_last, b_busy, b_done, b_rrow, b_rcol, b_row, b_col, b_data} !== '0)
      begin n_fail++; $display("FAIL rst_mid: got valid=%b busy=%b re=%b data=%h, required all zero", b_valid, b_busy, b_re, b_data); end
    for (int c = 0; c < 12; c++) begin
      tick();
      if (b_valid || b_done || b_busy) bad++;
    end
    n_tests++;
    if (bad !== 0)
      begin n_fail++; $display("FAIL rst_quiet: got %0d active cycles, required 0", bad); end
    test_full_tile_b(0, 0);
  endtask

  initial begin
    rst = 1'b1;
    a_start = 1'b0; a_flush = 1'b0; a_rdy = 1'b0;
    b_start = 1'b0; b_flush = 1'b0; b_rdy = 1'b0;
    d_start = 1'b0; d_flush = 1'b0; d_rdy = 1'b0;
    tick();
    test_reset();
    test_basic_2x2();
    test_back_to_back();
    test_start_while_busy();
    test_start_flush_same();
    test_single();
    test_full_tile_b(1, 0);
    test_full_tile_b(0, 20);
    test_flush_mid_tile();
    test_rst_mid_tile();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required normal completion");
    $fatal(1);
  end

endmodule

// File: doc/c_tile_reader.md
C_TILE_READER -- requirements
Module: c_tile_reader

Interface
REQ-001 Parameter M, default 8, tile rows.
REQ-002 Parameter N, default 8, tile columns.
REQ-003 Parameter DATA_W, default 32, element width.
REQ-004 Parameter ROW_W, default (M<=1)?1:$clog2(M), row index width.
REQ-005 Parameter COL_W, default (N<=1)?1:$clog2(N), column index width.
REQ-006 Parameter RD_LAT, default 1, fixed C SRAM read latency in cycles (>=1).
REQ-007 Parameter FIFO_DEPTH, default RD_LAT+2, output buffer entries.
REQ-008 clk  in  1  single clock; all logic on posedge.
REQ-009 rst  in  1  synchronous, active-high reset.
REQ-010 start  in  1  pulse; begin streaming one M x N tile; ignored unless idle.
REQ-011 flush  in  1  abort current tile, discard in-flight and buffered data.
REQ-012 c_re  out  1  C SRAM read enable.
REQ-013 c_rrow  out  ROW_W  read row address.
REQ-014 c_rcol  out  COL_W  read column address.
REQ-015 c_rdata  in  DATA_W  read data, valid exactly RD_LAT cycles after c_re.
REQ-016 out_valid  out  1  stream element valid.
REQ-017 out_ready  in  1  downstream accept.
REQ-018 out_data  out  DATA_W  element value.
REQ-019 out_row / out_col  out  ROW_W / COL_W  element coordinates.
REQ-020 out_last  out  1  high with element (M-1,N-1).
REQ-021 busy  out  1  high in any state except IDLE.
REQ-022 done  out  1  one-cycle pulse after last element is accepted.

Function
REQ-023 FSM states IDLE, RUN, DRAIN; IDLE->RUN on start; RUN->DRAIN when M*N reads issued; DRAIN->IDLE when last element handshaked (out_valid&&out_ready&&out_last), done pulsed same edge.
REQ-024 Reads issue in row-major order (0,0),(0,1)...(M-1,N-1); address counters wrap col N-1->0 with row increment.
REQ-025 c_re asserted in RUN only when issued<M*N and (inflight + fifo_count) < FIFO_DEPTH; c_rrow/c_rcol valid whenever c_re high, held at current counter otherwise.
REQ-026 inflight counts reads issued whose data has not returned; a delay line of RD_LAT stages tags each return with its row/col.
REQ-027 Returning data pushed into FIFO at the cycle it is valid; FIFO never overflows by construction of REQ-025.
REQ-028 out_valid = FIFO non-empty; out_data/out_row/out_col/out_last from FIFO head, registered (no combinational path c_rdata->out_data).
REQ-029 Pop when out_valid&&out_ready; simultaneous push and pop allowed, count unchanged.
REQ-030 out_data/out_row/out_col stable while out_valid&&!out_ready.
REQ-031 Latency: start at cycle t -> first c_re at t+1 -> out_valid at t+2+RD_LAT.
REQ-032 With out_ready held high, throughput is one element per cycle; tile completes M*N+RD_LAT+1 cycles after start, done at the following edge.
REQ-033 start while busy ignored; start and flush same cycle: flush wins, stays IDLE.
REQ-034 flush: next cycle state IDLE, counters, FIFO and delay line cleared, out_valid=0, no done pulse; returning data from reads issued before flush dropped.
REQ-035 M=1 or N=1 handled (single-index wrap); M*N=1 tile produces exactly one element with out_last=1.

Reset
REQ-036 On rst: state IDLE, c_re=0, c_rrow=0, c_rcol=0, out_valid=0, out_last=0, out_data=0, out_row=0, out_col=0, busy=0, done=0, FIFO and inflight empty; rst overrides start and flush.
REQ-037 rst mid-tile behaves as flush plus output register clear; next start begins at (0,0).

Verification
REQ-038 M=N=2, RD_LAT=1, SRAM model mem[i][j]=i*16+j, out_ready=1, start at cycle 0 -> out 0x00,0x01,0x10,0x11 at cycles 3..6, out_last at cycle 6, done at cycle 7.
REQ-039 8x8 tile, out_ready toggles 1,0 each cycle -> 64 elements in row-major order, no loss/duplication, data stable during stalls, FIFO count never exceeds FIFO_DEPTH.
REQ-040 out_ready=0 for 20 cycles after start, RD_LAT=3 -> exactly FIFO_DEPTH=5 reads issued then c_re=0; release -> remaining elements correct.
REQ-041 flush asserted at element 10 of 8x8 tile -> out_valid=0 next cycle, no done, busy=0; new start streams from (0,0) with correct data.
REQ-042 start pulsed again while busy, and rst at cycle 5 of a tile -> second start ignored; after rst all outputs at reset values, no stale data emitted.
